// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pulls words from a registered-output FIFO and presents
// them as a valid/ready stream with burst framing (m_last) and a beat count.
// Reads are issued on credit: a word already in flight or buffered holds a
// slot, so the 3-entry buffer can absorb every read issued before a stall.
`timescale 1ns/1ps

module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [15:0]           word_cnt
);

  localparam int          DEPTH    = 3;
  localparam logic [15:0] BEAT_MAX = 16'(BURST_LEN - 1);

  // Output buffer storage and bookkeeping.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [1:0]            head_q, head_d;
  logic [1:0]            tail_q, tail_d;
  logic [1:0]            count_q, count_d;
  logic                  inflight_q, inflight_d;
  logic [15:0]           beat_q, beat_d;
  logic [15:0]           word_cnt_q, word_cnt_d;

  logic                  capture;
  logic                  accept;
  logic [2:0]            credit_used;

  // Circular pointer step over entries 0, 1, 2.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Read strobe: issue only while a buffer slot is free for the returning word.
  always_comb begin
    credit_used = {1'b0, count_q} + {2'b00, inflight_q};
    fifo_r_en   = enable & ~fifo_empty & ~rst & (credit_used < 3'd3);
  end

  // Stream outputs straight from the buffer registers.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    m_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (head_q == 2'(i)) m_data = mem_q[i];
    end
    m_valid  = (count_q != 2'd0);
    m_last   = m_valid & (beat_q == BEAT_MAX);
    word_cnt = word_cnt_q;
  end

  // Next-state: capture at the tail, retire at the head, framing counters.
  always_comb begin
    capture    = inflight_q;
    accept     = m_valid & m_ready;

    mem_d      = mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    inflight_d = fifo_r_en;
    beat_d     = beat_q;
    word_cnt_d = word_cnt_q;

    if (capture) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (tail_q == 2'(i)) mem_d[i] = fifo_data;
      end
      tail_d = ptr_inc(tail_q);
    end

    if (accept) begin
      head_d     = ptr_inc(head_q);
      word_cnt_d = word_cnt_q + 16'd1;
      beat_d     = (beat_q == BEAT_MAX) ? 16'd0 : beat_q + 16'd1;
    end

    // Capture and retire in the same cycle cancel out.
    unique case ({capture, accept})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset drops buffered words and any word still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the three data entries are reset too, so m_data reads 0 while
      // in reset; a deeper buffer would leave storage unreset and gate m_data.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q     <= 2'd0;
      tail_q     <= 2'd0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      beat_q     <= 16'd0;
      word_cnt_q <= 16'd0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge value of the others, independent of statement order.
      mem_q      <= mem_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      beat_q     <= beat_d;
      word_cnt_q <= word_cnt_d;
    end
  end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-002 Parameter DATA_WIDTH SHALL default to 8 and set the data word width.
REQ-003 Parameter BURST_LEN SHALL default to 4 and set the beats per burst; the legal range is 1..65535.
REQ-004 Port clk SHALL be an input, 1 bit wide: the system clock; all state updates on its rising edge.
REQ-005 Port rst SHALL be an input, 1 bit wide: synchronous active-high reset.
REQ-006 Port enable SHALL be an input, 1 bit wide: when high, new FIFO reads are permitted.
REQ-007 Port fifo_empty SHALL be an input, 1 bit wide: the FIFO empty flag.
REQ-008 Port fifo_data SHALL be an input, DATA_WIDTH bits wide: FIFO read data, registered, valid the cycle after the read strobe.
REQ-009 Port fifo_r_en SHALL be an output, 1 bit wide: the FIFO read strobe.
REQ-010 Port m_data SHALL be an output, DATA_WIDTH bits wide: the stream data.
REQ-011 Port m_valid SHALL be an output, 1 bit wide: the stream valid.
REQ-012 Port m_ready SHALL be an input, 1 bit wide: the stream ready from the downstream consumer.
REQ-013 Port m_last SHALL be an output, 1 bit wide: high on the final beat of each burst.
REQ-014 Port word_cnt SHALL be an output, 16 bits wide: the count of accepted stream beats.

Function
REQ-015 The block SHALL contain a 3-entry circular output buffer with a 2-bit occupancy count (0..3) and a 1-bit in-flight register.
REQ-016 fifo_r_en SHALL be combinational: enable & !fifo_empty & !rst & (count + inflight < 3); it SHALL depend on no other inputs, and in particular not on m_ready.
REQ-017 The in-flight register SHALL load fifo_r_en each cycle.
REQ-018 When in-flight is 1, fifo_data SHALL be written into the buffer tail at that edge, regardless of enable.
REQ-019 FIFO-to-stream latency SHALL be 2 cycles: with fifo_r_en high in cycle N and the buffer previously empty, m_valid SHALL be high in cycle N+2 with that word on m_data.
REQ-020 m_valid SHALL equal (count != 0), and m_data SHALL be the buffer head, driven from registers.
REQ-021 A beat SHALL be accepted when m_valid & m_ready; on acceptance the head SHALL advance.
REQ-022 Simultaneous capture and acceptance SHALL leave the count unchanged.
REQ-023 m_data SHALL remain stable while m_valid is high and m_ready is low.
REQ-024 Sustained throughput SHALL be one beat per cycle when the FIFO is non-empty, m_ready=1 and enable=1.
REQ-025 Buffer pointers SHALL wrap 2 -> 0.
REQ-026 The buffer SHALL never overflow; the credit rule in REQ-016 guarantees this.
REQ-027 A beat counter (0..BURST_LEN-1) SHALL increment on each accepted beat and wrap to 0 after BURST_LEN-1.
REQ-028 m_last SHALL equal m_valid & (beat == BURST_LEN-1).
REQ-029 With BURST_LEN=1, m_last SHALL equal m_valid.
REQ-030 word_cnt SHALL increment by 1 per accepted beat, modulo 2^16 (0xFFFF -> 0x0000).
REQ-031 Deasserting enable SHALL stop new reads only; buffered and in-flight words SHALL still drain.
REQ-032 A burst SHALL NOT be truncated by enable; the beat position SHALL persist.
REQ-033 fifo_empty sampled high SHALL block fifo_r_en in the same cycle; no read SHALL be issued to an empty FIFO.

Reset
REQ-034 While rst is high, the block SHALL hold fifo_r_en=0, m_valid=0, m_last=0, m_data=0 and word_cnt=0.
REQ-035 While rst is high, the block SHALL hold count, pointers, in-flight and the beat counter at 0.
REQ-036 Reset asserted mid-operation SHALL discard buffered and in-flight words; a word returned on fifo_data during reset SHALL NOT be captured.
REQ-037 The first cycle after rst deasserts SHALL be able to issue fifo_r_en.

Verification
REQ-038 Scenario latency: FIFO preloaded with 0xA1, m_ready=1, enable=1, reset released -> fifo_r_en high in cycle 0 after reset; m_valid high in cycle 2 with m_data=0xA1; word_cnt=1 after cycle 2.
REQ-039 Scenario streaming: 8 words 0x00..0x07 and BURST_LEN=4 -> one beat per cycle after the 2-cycle fill; m_last high on 0x03 and 0x07; word_cnt=8.
REQ-040 Scenario backpressure: m_ready=0 with FIFO non-empty -> exactly 3 reads issued, then fifo_r_en=0 while count=3; m_data is held; releasing m_ready delivers the words in order with no loss.
REQ-041 Scenario enable drop: enable deasserted mid-burst after beat 1 -> no new reads; in-flight and buffered words drain; re-enabling resumes with m_last on the correct 4th beat.
REQ-042 Scenario wrap and reset: word_cnt preset to 0xFFFE via 2 extra beats -> 0x0000 observed; rst pulsed with count=2 and in-flight=1 -> all outputs 0 the next cycle and no stale word appears afterwards.
